minterm_lut_engine: RTL and testbench

// - Runtime-programmable N_IN-input Boolean function evaluator: truth table held in a 2^N_IN-bit register.
// - Evaluates one input vector per cycle over a valid/ready stream, with a registered output.
// - Table is reloadable word-by-word over a config stream. Sits between an input-vector source and a result sink.

---
 rtl/minterm_lut_pkg.sv | 35 +++
 rtl/minterm_lut_cfg_loader.sv | 90 +++++++++
 rtl/minterm_lut_engine.sv | 116 +++++++++++
 tb/tb_minterm_lut_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/minterm_lut_pkg.sv
// ----------------------------------------------------------------------------
// minterm_lut_pkg
// Shared constants, FSM state type and default truth-table helper for the
// minterm LUT engine.
//   CNT_W        : width of the optional evaluation/hit counters
//   DEFAULT_TT_6 : power-up truth table for the 6-input build
//                  (minterms 0,4,8,10,12,16,20,24,26,28,40,42,44,46,56,58)
//   default_tt() : returns the reset table for a given input width
//                  (DEFAULT_TT_6 for 6 inputs, all zeros otherwise)
// Optional feature macro used by the engine: MINTERM_HIT_CNT_EN
// ----------------------------------------------------------------------------
package minterm_lut_pkg;

    localparam int CNT_W    = 16;
    localparam int MAX_TT_W = 1024;   // table depth for the largest legal N_IN (10)

    localparam logic [63:0] DEFAULT_TT_6 = 64'h0500_5500_1511_1511;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } lut_state_e;

    // Returned at the maximum width; callers keep the low 2**n_in bits.
    function automatic logic [MAX_TT_W-1:0] default_tt(input int n_in);
        logic [MAX_TT_W-1:0] tt;
        tt = '0;
        if (n_in == 6) begin
            tt[63:0] = DEFAULT_TT_6;
        end
        return tt;
    endfunction

endpackage

// File: rtl/minterm_lut_cfg_loader.sv
// ----------------------------------------------------------------------------
// minterm_lut_cfg_loader
// Table reload controller: RUN -> LOAD -> COMMIT -> RUN.  Config words are
// collected into a shadow register and copied to the active table in a single
// COMMIT cycle, so evaluation never sees a half-written table.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   cfg_start       : begin a load (honoured only in RUN)
//   cfg_valid/ready : config word handshake (ready only in LOAD)
//   cfg_data        : word k lands in shadow bits [k*CFG_W +: CFG_W]
//   busy            : high in LOAD and COMMIT
//   o_table         : currently active (committed) truth table
//   o_commit        : high during the COMMIT cycle
// ----------------------------------------------------------------------------
module minterm_lut_cfg_loader
    import minterm_lut_pkg::*;
#(
    parameter int              TT_W     = 64,
    parameter int              CFG_W    = 8,
    parameter logic [TT_W-1:0] RESET_TT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CFG_W-1:0] cfg_data,
    output logic             busy,
    output logic [TT_W-1:0]  o_table,
    output logic             o_commit
);

    localparam int NW  = TT_W / CFG_W;
    localparam int K_W = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NW - 1);

    lut_state_e      r_state;
    logic [K_W-1:0]  r_k;
    logic [TT_W-1:0] r_shadow;
    logic [TT_W-1:0] r_table;
    logic            w_cfg_accept;

    // Gated by rst so no word can be handshaken while reset is asserted.
    assign cfg_ready    = (r_state == LOAD) && !rst;
    assign w_cfg_accept = cfg_valid && cfg_ready;
    assign busy         = (r_state != RUN);
    assign o_commit     = (r_state == COMMIT);
    assign o_table      = r_table;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_k      <= '0;
            r_shadow <= '0;
            r_table  <= RESET_TT;
        end else begin
            case (r_state)
                RUN: begin
                    if (cfg_start) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_cfg_accept) begin
                        // Constant-index slices keep the write decode simple.
                        for (int w = 0; w < NW; w++) begin
                            if (r_k == K_W'(w)) begin
                                r_shadow[w*CFG_W +: CFG_W] <= cfg_data;
                            end
                        end
                        if (r_k == K_LAST) begin
                            r_state <= COMMIT;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    r_table <= r_shadow;
                    r_k     <= '0;
                    r_state <= RUN;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: rtl/minterm_lut_engine.sv
// ----------------------------------------------------------------------------
// minterm_lut_engine
// Runtime-programmable N_IN-input Boolean function evaluator.  Each accepted
// input vector indexes the 2**N_IN-bit truth table; the result is registered
// and presented on a valid/ready output stream one cycle later.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   cfg_start/valid/ready/data: table reload stream (see cfg loader)
//   in_valid/in_ready/in_vec  : input vector stream (minterm index)
//   out_valid/out_ready/out_y : result stream, out_y = table[in_vec]
//   busy                      : table reload in progress (LOAD or COMMIT)
//   hit_cnt, eval_cnt         : only with MINTERM_HIT_CNT_EN defined;
//                               saturating counts of 1-results / accepts,
//                               cleared by rst and by each table commit
// Build option: `define MINTERM_HIT_CNT_EN to add the counters.
// ----------------------------------------------------------------------------
module minterm_lut_engine
    import minterm_lut_pkg::*;
#(
    parameter int N_IN  = 6,
    parameter int CFG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y,
    output logic             busy
`ifdef MINTERM_HIT_CNT_EN
    ,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] eval_cnt
`endif
);

    localparam int TT_W = 1 << N_IN;
    localparam logic [MAX_TT_W-1:0] DEFAULT_TT_FULL = default_tt(N_IN);
    localparam logic [TT_W-1:0]     DEFAULT_TT      = DEFAULT_TT_FULL[TT_W-1:0];

    logic [TT_W-1:0] w_table;
    logic            w_commit;
    logic            w_busy;
    logic            w_in_accept;
    logic            w_result;
    logic            r_out_valid;
    logic            r_out_y;

    minterm_lut_cfg_loader #(
        .TT_W     (TT_W),
        .CFG_W    (CFG_W),
        .RESET_TT (DEFAULT_TT)
    ) u_cfg_loader (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .busy      (w_busy),
        .o_table   (w_table),
        .o_commit  (w_commit)
    );

    // Accept only in RUN and only when the output slot is free or draining.
    assign in_ready    = !rst && !w_busy && (!r_out_valid || out_ready);
    assign w_in_accept = in_valid && in_ready;
    assign w_result    = w_table[in_vec];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_y     <= 1'b0;
        end else if (w_in_accept) begin
            r_out_valid <= 1'b1;
            r_out_y     <= w_result;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign busy      = w_busy;

`ifdef MINTERM_HIT_CNT_EN
    logic [CNT_W-1:0] r_eval_cnt;
    logic [CNT_W-1:0] r_hit_cnt;

    // No accept can coincide with COMMIT (in_ready is low), so clearing
    // there never loses an event.
    always_ff @(posedge clk) begin
        if (rst || w_commit) begin
            r_eval_cnt <= '0;
            r_hit_cnt  <= '0;
        end else if (w_in_accept) begin
            if (r_eval_cnt != '1) begin
                r_eval_cnt <= r_eval_cnt + 1'b1;
            end
            if (w_result && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
        end
    end

    assign eval_cnt = r_eval_cnt;
    assign hit_cnt  = r_hit_cnt;
`endif

endmodule

// File: tb/tb_minterm_lut_engine.sv
// ----------------------------------------------------------------------------
// tb_minterm_lut_engine
// Directed test of minterm_lut_engine (N_IN = 6, CFG_W = 8): default table,
// table reload, backpressure, reset during load, start/accept overlap and,
// when MINTERM_HIT_CNT_EN is defined, the evaluation/hit counters.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_minterm_lut_engine;

    logic       clk;
    logic       rst;
    logic       cfg_start;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_data;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic       out_y;
    logic       busy;
`ifdef MINTERM_HIT_CNT_EN
    logic [15:0] hit_cnt;
    logic [15:0] eval_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    minterm_lut_engine #(
        .N_IN  (6),
        .CFG_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy)
`ifdef MINTERM_HIT_CNT_EN
        ,
        .hit_cnt   (hit_cnt),
        .eval_cnt  (eval_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One vector through the engine with out_ready high; result checked the
    // cycle after the accept.
    task automatic eval_vec(input string tag, input logic [5:0] v, input logic exp);
        int waited;
        waited = 0;
        @(posedge clk); #1;
        in_vec   = v;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk({tag, "_timeout"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_vld"}, out_valid, 1);
        chk(tag, out_y, exp);
    endtask

    task automatic start_load();
        @(posedge clk); #1;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    // Called just after the engine entered LOAD; sends all 8 words back to
    // back and checks the 8 + 1 cycles of in_ready low.
    task automatic full_load(input string tag, input logic [7:0] w);
        int low_cycles;
        low_cycles = 0;
        cfg_valid  = 1'b1;
        cfg_data   = w;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!in_ready) low_cycles++;
            if (i == 0) begin
                chk({tag, "_cfg_ready"}, cfg_ready, 1);
                chk({tag, "_busy"}, busy, 1);
            end
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
        @(negedge clk);
        if (!in_ready) low_cycles++;
        chk({tag, "_commit_cfg_ready"}, cfg_ready, 0);
        chk({tag, "_commit_busy"}, busy, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_run_busy"}, busy, 0);
        chk({tag, "_run_in_ready"}, in_ready, 1);
        chk({tag, "_low_cycles"}, low_cycles, 9);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rs_out_valid", out_valid, 0);
        chk("rs_out_y", out_y, 0);
        chk("rs_busy", busy, 0);
        chk("rs_cfg_ready", cfg_ready, 0);
        chk("rs_in_ready", in_ready, 1);

        // Default table
        eval_vec("def_10", 6'd10, 1'b1);
        eval_vec("def_1", 6'd1, 1'b0);
        eval_vec("def_46", 6'd46, 1'b1);
        eval_vec("def_63", 6'd63, 1'b0);

        // Reload with 8 x 8'h01 -> minterms 0,8,16,...,56
        start_load();
        full_load("ld01", 8'h01);
        eval_vec("ld01_8", 6'd8, 1'b1);
        eval_vec("ld01_16", 6'd16, 1'b1);
        eval_vec("ld01_4", 6'd4, 1'b0);
        eval_vec("ld01_10", 6'd10, 1'b0);

        // Backpressure on the default table: 0 then 4
        do_reset();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_vec    = 6'd0;
        in_valid  = 1'b1;
        @(negedge clk);
        chk("bp_first_ready", in_ready, 1);
        @(posedge clk); #1;
        in_vec = 6'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stall_ready", in_ready, 0);
            chk("bp_stall_vld", out_valid, 1);
            chk("bp_stall_y", out_y, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_vld", out_valid, 1);
        chk("bp_second_y", out_y, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_drained", out_valid, 0);

        // Reset after 3 of 8 words of 8'hFF
        start_load();
        cfg_valid = 1'b1;
        cfg_data  = 8'hFF;
        repeat (3) begin
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rl_busy", busy, 0);
        chk("rl_cfg_ready", cfg_ready, 0);
        eval_vec("rl_58", 6'd58, 1'b1);
        eval_vec("rl_1", 6'd1, 1'b0);

        // cfg_start together with accept of vec 0: old table applies
        @(posedge clk); #1;
        in_vec    = 6'd0;
        in_valid  = 1'b1;
        cfg_start = 1'b1;
        @(negedge clk);
        chk("ov_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        cfg_start = 1'b0;
        @(negedge clk);
        chk("ov_vld", out_valid, 1);
        chk("ov_y_old", out_y, 1);
        chk("ov_busy", busy, 1);
        @(posedge clk); #1;
        full_load("ld00", 8'h00);
        eval_vec("ld00_0", 6'd0, 1'b0);

`ifdef MINTERM_HIT_CNT_EN
        do_reset();
        eval_vec("cnt_0", 6'd0, 1'b1);
        eval_vec("cnt_1", 6'd1, 1'b0);
        eval_vec("cnt_4", 6'd4, 1'b1);
        eval_vec("cnt_2", 6'd2, 1'b0);
        eval_vec("cnt_8", 6'd8, 1'b1);
        chk("cnt_eval", eval_cnt, 5);
        chk("cnt_hit", hit_cnt, 3);
        start_load();
        full_load("cntld", 8'h00);
        chk("cnt_eval_clr", eval_cnt, 0);
        chk("cnt_hit_clr", hit_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
